// File: rtl/s2p_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : s2p_pkg                                                     |
// | Description: Shared types and helpers for serial_to_parallel_stream.     |
// |              s2p_order_e selects where successive beats land in a word.  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package s2p_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } s2p_order_e;

  // Bit offset of the low bit of beat k inside a word.
  // LSB_FIRST fills upward from bit 0; MSB_FIRST fills downward from the top.
  function automatic int s2p_shift(input s2p_order_e order, input int k,
                                   input int lanes, input int width);
    if (order == MSB_FIRST) begin
      return width - (k + 1) * lanes;
    end
    return k * lanes;
  endfunction

endpackage : s2p_pkg
`default_nettype wire

// File: rtl/serial_to_parallel_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : serial_to_parallel_stream                                   |
// | Description: Gathers LANES-bit beats into WIDTH-bit words behind a       |
// |              valid/ready handshake on both sides. A word closes when it  |
// |              is full or when in_last is seen; unused bits read as 0.     |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   clock, rising edge                                     |
// |   rst        in   asynchronous active-high reset                         |
// |   in_valid   in   input beat offered                                     |
// |   in_ready   out  beat accepted this cycle (!out_valid || out_ready)     |
// |   in_data    in   LANES-bit beat payload                                 |
// |   in_last    in   beat closes the packet and flushes the word            |
// |   out_valid  out  out_data/out_beats/out_last hold a word                |
// |   out_ready  in   consumer takes the word this cycle                     |
// |   out_data   out  assembled word                                         |
// |   out_beats  out  beats in the word, 1..WIDTH/LANES                      |
// |   out_last   out  word was closed by in_last                             |
// +--------------------------------------------------------------------------+
module serial_to_parallel_stream
  import s2p_pkg::*;
#(
  parameter int         WIDTH = 8,
  parameter int         LANES = 1,
  parameter s2p_order_e ORDER = LSB_FIRST
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [LANES-1:0]                   in_data,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [$clog2(WIDTH/LANES+1)-1:0]   out_beats,
  output logic                               out_last
);

  localparam int c_beats = WIDTH / LANES;
  localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_nb_w  = $clog2(c_beats + 1);

  generate
    if ((LANES < 1) || (WIDTH % LANES != 0)) begin : g_bad_lanes
      $error("serial_to_parallel_stream: WIDTH must be a multiple of LANES");
    end
  endgenerate

  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_acc;

  logic               w_accept;
  logic               w_full;
  logic               w_done;
  logic [WIDTH-1:0]   w_acc_next;

  // The output register can take a new word whenever it is empty or being
  // drained this cycle, so the accept path never waits a bubble.
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_full     = (r_cnt == c_cnt_w'(c_beats - 1));
  assign w_done     = w_accept && (w_full || in_last);

  // Accumulator starts each word at zero, so OR-ing the beat in is enough
  // and positions never written in a short word stay 0.
  assign w_acc_next = r_acc | (WIDTH'(in_data) << s2p_shift(ORDER, int'(r_cnt), LANES, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_done) begin
          // A word finishing in the drain cycle overrides the drop above.
          out_valid <= 1'b1;
          out_data  <= w_acc_next;
          out_beats <= c_nb_w'(r_cnt) + c_nb_w'(1);
          out_last  <= in_last;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc     <= w_acc_next;
          r_cnt     <= r_cnt + c_cnt_w'(1);
        end
      end
    end
  end

endmodule : serial_to_parallel_stream
`default_nettype wire

// File: tb/tb_serial_to_parallel_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_serial_to_parallel_stream                                |
// | Description: Self-checking bench. Three instances share clk/rst:         |
// |              d0 = 8/1 LSB_FIRST, d1 = 8/1 MSB_FIRST, d2 = 8/2 LSB_FIRST.  |
// |              Directed scenarios plus randomized traffic against a        |
// |              beat-list reference model.                                  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_serial_to_parallel_stream;
  import s2p_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [2:0] in_valid, in_last, out_ready;
  logic [1:0] in_data [3];
  logic [2:0] in_ready, out_valid, out_last;
  logic [7:0] od0, od1, od2;
  logic [3:0] ob0, ob1;
  logic [2:0] ob2;
  logic [7:0] out_data  [3];
  logic [3:0] out_beats [3];

  assign out_data[0]  = od0;
  assign out_data[1]  = od1;
  assign out_data[2]  = od2;
  assign out_beats[0] = ob0;
  assign out_beats[1] = ob1;
  assign out_beats[2] = {1'b0, ob2};

  serial_to_parallel_stream #(.WIDTH(8), .LANES(1), .ORDER(LSB_FIRST)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][0:0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od0), .out_beats(ob0), .out_last(out_last[0]));

  serial_to_parallel_stream #(.WIDTH(8), .LANES(1), .ORDER(MSB_FIRST)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][0:0]), .in_last(in_last[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od1), .out_beats(ob1), .out_last(out_last[1]));

  serial_to_parallel_stream #(.WIDTH(8), .LANES(2), .ORDER(LSB_FIRST)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2), .out_beats(ob2), .out_last(out_last[2]));

  // ---------------- reference model: list of accepted beats per instance
  logic       m_ov   [3];
  logic [7:0] m_word [3];
  int         m_nb   [3];
  logic       m_last [3];
  logic [1:0] m_beat [3][8];
  int         m_cnt  [3];

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ov[d] = 1'b0; m_cnt[d] = 0; m_word[d] = 8'h00; m_nb[d] = 0; m_last[d] = 1'b0;
    end
  endfunction

  // Advance one clock using the inputs currently applied.
  function automatic void model_step(input int d);
    bit         rdy;
    int         ln;
    int         sh;
    logic [7:0] w;
    ln  = (d == 2) ? 2 : 1;
    rdy = !m_ov[d] || out_ready[d];
    if (m_ov[d] && out_ready[d]) m_ov[d] = 1'b0;
    if (in_valid[d] && rdy) begin
      m_beat[d][m_cnt[d]] = (ln == 1) ? {1'b0, in_data[d][0]} : in_data[d];
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == 8 / ln || in_last[d]) begin
        w = 8'h00;
        for (int k = 0; k < m_cnt[d]; k++) begin
          sh = (d == 1) ? 8 - (k + 1) * ln : k * ln;
          w  = w | (8'(m_beat[d][k]) << sh);
        end
        m_word[d] = w; m_nb[d] = m_cnt[d]; m_last[d] = in_last[d];
        m_ov[d] = 1'b1; m_cnt[d] = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers
  task automatic drive(input int d, input logic v, input logic [1:0] dat, input logic l);
    in_valid[d] = v; in_data[d] = dat; in_last[d] = l;
  endtask

  task automatic idle_all();
    in_valid = 3'b000; in_last = 3'b000;
    for (int d = 0; d < 3; d++) in_data[d] = 2'b00;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst = 1'b1; idle_all(); out_ready = 3'b111;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || out_data[d] !== 8'h00 || out_beats[d] !== 4'd0 || out_last[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs d%0d: got v=%b data=%h beats=%0d last=%b, want all 0",
                 d, out_valid[d], out_data[d], out_beats[d], out_last[d]);
      end
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready d%0d: got %b want 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_known_words();
    logic [7:0] bits;
    logic [1:0] b2 [4];
    bits = 8'h4D;
    b2[0] = 2'b01; b2[1] = 2'b10; b2[2] = 2'b11; b2[3] = 2'b00;
    @(negedge clk); idle_all(); out_ready = 3'b111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2] !== 8'h39 || out_beats[2] !== 4'd4 || out_last[2] !== 1'b0) begin
          failures++;
          $display("FAIL lanes2_word: got v=%b data=%h beats=%0d last=%b, want 1/39/4/0",
                   out_valid[2], out_data[2], out_beats[2], out_last[2]);
        end
      end
      if (i == 5) begin
        checks++;
        if (out_valid[2] !== 1'b0) begin
          failures++;
          $display("FAIL lanes2_drop: got out_valid=%b want 0", out_valid[2]);
        end
      end
      drive(0, 1'b1, {1'b0, bits[i]}, 1'b0);
      drive(1, 1'b1, {1'b0, bits[i]}, 1'b0);
      if (i < 4) drive(2, 1'b1, b2[i], 1'b0);
      else       drive(2, 1'b0, 2'b00, 1'b0);
    end
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h4D || out_beats[0] !== 4'd8 || out_last[0] !== 1'b0) begin
      failures++;
      $display("FAIL lsb_word: got v=%b data=%h beats=%0d last=%b, want 1/4d/8/0",
               out_valid[0], out_data[0], out_beats[0], out_last[0]);
    end
    checks++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== 8'hB2 || out_beats[1] !== 4'd8 || out_last[1] !== 1'b0) begin
      failures++;
      $display("FAIL msb_word: got v=%b data=%h beats=%0d last=%b, want 1/b2/8/0",
               out_valid[1], out_data[1], out_beats[1], out_last[1]);
    end
  endtask

  task automatic test_partial();
    @(negedge clk); idle_all(); out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 1'b1, 2'b01, (i == 2));
    end
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h07 || out_beats[0] !== 4'd3 || out_last[0] !== 1'b1) begin
      failures++;
      $display("FAIL partial_word: got v=%b data=%h beats=%0d last=%b, want 1/07/3/1",
               out_valid[0], out_data[0], out_beats[0], out_last[0]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 1'b1, {1'b0, (i == 0)}, 1'b0);
    end
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h01 || out_beats[0] !== 4'd8 || out_last[0] !== 1'b0) begin
      failures++;
      $display("FAIL after_partial_word: got v=%b data=%h beats=%0d last=%b, want 1/01/8/0",
               out_valid[0], out_data[0], out_beats[0], out_last[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    pat = 8'hA5;
    @(negedge clk); idle_all(); out_ready = 3'b111;
    @(negedge clk); out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, {1'b0, pat[i]}, 1'b0); @(negedge clk);
    end
    idle_all();
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 2'b01, 1'b0);
      @(negedge clk);
      checks++;
      if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || out_data[0] !== 8'hA5 ||
          out_beats[0] !== 4'd8 || out_last[0] !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold c%0d: got rdy=%b v=%b data=%h beats=%0d last=%b, want 0/1/a5/8/0",
                 c, in_ready[0], out_valid[0], out_data[0], out_beats[0], out_last[0]);
      end
    end
    out_ready[0] = 1'b1;
    drive(0, 1'b1, 2'b01, 1'b1);
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h01 || out_beats[0] !== 4'd1 || out_last[0] !== 1'b1) begin
      failures++;
      $display("FAIL no_bubble_one_beat: got v=%b data=%h beats=%0d last=%b, want 1/01/1/1",
               out_valid[0], out_data[0], out_beats[0], out_last[0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL drop_after_take: got out_valid=%b want 0", out_valid[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pat;
    pat = 8'h96;
    @(negedge clk); idle_all(); out_ready = 3'b011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(0, 1'b1, 2'b01, 1'b0); drive(2, 1'b1, 2'b11, 1'b0);
    end
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== 8'hFF) begin
      failures++;
      $display("FAIL pre_reset_word: got v=%b data=%h want 1/ff", out_valid[2], out_data[2]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid[2] !== 1'b0 || out_data[2] !== 8'h00 || out_beats[2] !== 4'd0 ||
        out_last[2] !== 1'b0 || out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got v2=%b data2=%h beats2=%0d last2=%b v0=%b, want all 0",
               out_valid[2], out_data[2], out_beats[2], out_last[2], out_valid[0]);
    end
    #1 rst = 1'b0;
    out_ready = 3'b111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (out_valid[0] !== 1'b0) begin
          failures++;
          $display("FAIL partial_discarded: got out_valid=%b after 4 beats, want 0", out_valid[0]);
        end
      end
      drive(0, 1'b1, {1'b0, pat[i]}, 1'b0);
    end
    @(negedge clk); idle_all();
    checks++;
    if (out_valid[0] !== 1'b1 || out_data[0] !== 8'h96 || out_beats[0] !== 4'd8 || out_last[0] !== 1'b0) begin
      failures++;
      $display("FAIL clean_word_after_reset: got v=%b data=%h beats=%0d last=%b, want 1/96/8/0",
               out_valid[0], out_data[0], out_beats[0], out_last[0]);
    end
  endtask

  task automatic test_random();
    @(negedge clk); idle_all(); out_ready = 3'b111;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (out_valid[d] !== m_ov[d] || in_ready[d] !== (!m_ov[d] || out_ready[d])) begin
          failures++;
          $display("FAIL rand_handshake n%0d d%0d: got v=%b rdy=%b, want v=%b rdy=%b",
                   n, d, out_valid[d], in_ready[d], m_ov[d], (!m_ov[d] || out_ready[d]));
        end
        if (m_ov[d]) begin
          checks++;
          if (out_data[d] !== m_word[d] || out_beats[d] !== 4'(m_nb[d]) || out_last[d] !== m_last[d]) begin
            failures++;
            $display("FAIL rand_word n%0d d%0d: got data=%h beats=%0d last=%b, want %h/%0d/%b",
                     n, d, out_data[d], out_beats[d], out_last[d], m_word[d], m_nb[d], m_last[d]);
          end
        end
      end
      for (int d = 0; d < 3; d++) begin
        drive(d, ($urandom_range(0, 99) < 70), 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15));
        out_ready[d] = ($urandom_range(0, 99) < 60);
        model_step(d);
      end
    end
    idle_all();
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    out_ready = 3'b111;
    test_reset();
    test_known_words();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_to_parallel_stream
`default_nettype wire
